// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for a byte-addressed data memory with combinational read data.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into byte accesses; otherwise they are rejected.
module lsu_mem_master #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_misaligned,
  output logic              o_rsp_illegal,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state;
  logic              req_ready_q, rsp_valid_q, rsp_misaligned_q, rsp_illegal_q;
  logic [31:0]       rsp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_bmask_q;
  logic              mem_wren_q;
  logic              we_p0;
  logic [2:0]        funct3_p0;
  logic [1:0]        lane_p0;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    logic r;
    if (we) r = (f3 > 3'd2);
    else    r = (f3 == 3'd3) || (f3 > 3'd5);
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic r;
    case (sz)
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] r;
    case (sz)
      2'b00:   r = 4'b0001;
      2'b01:   r = 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st_format(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {24'd0, d[7:0]};
      2'b01:   r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Right-aligned data in, sign- or zero-extended result out (funct3[2] selects unsigned).
  function automatic logic [31:0] ld_extend(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {{24{d[7] & ~f3[2]}}, d[7:0]};
      2'b01:   r = {{16{d[15] & ~f3[2]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic        req_fire, req_illegal, req_misaligned;
  logic        split_more;
  logic [31:0] aligned_ld, ld_result;
  logic        unused_addr_hi;

  assign req_fire       = i_req_valid && req_ready_q;
  assign req_illegal    = is_illegal(i_req_we, i_req_funct3);
  assign req_misaligned = is_misaligned(i_req_funct3[1:0], i_req_addr[1:0]);
  assign aligned_ld     = ld_extend(i_mem_rdata >> {lane_p0, 3'b000}, funct3_p0);
  assign unused_addr_hi = ^i_req_addr[31:ADDR_W];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_p0;
  logic [1:0]  k_p0, last_p0, k_nxt;
  logic [31:0] wdata_p0, asm_p0, asm_next;
  logic [7:0]  wd_byte;

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    logic [1:0] r;
    case (sz)
      2'b01:   r = 2'd1;
      2'b10:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign k_nxt      = k_p0 + 2'd1;
  assign wd_byte    = wdata_p0[{k_nxt, 3'b000} +: 8];
  assign split_more = split_p0 && (k_p0 != last_p0);
  assign ld_result  = split_p0 ? ld_extend(asm_next, funct3_p0) : aligned_ld;

  // Byte k of a split load comes from the lane of the address currently on the bus.
  always_comb begin
    asm_next = asm_p0;
    asm_next[{k_p0, 3'b000} +: 8] = i_mem_rdata[{mem_addr_q[1:0], 3'b000} +: 8];
  end
`else
  assign split_more = 1'b0;
  assign ld_result  = aligned_ld;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= S_IDLE;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_misaligned_q <= 1'b0;
      rsp_illegal_q    <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_bmask_q      <= '0;
      mem_wren_q       <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      k_p0             <= '0;
      split_p0         <= 1'b0;
`endif
    end else begin
      case (state)
        // Request capture
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_fire) begin
            req_ready_q <= 1'b0;
            we_p0       <= i_req_we;
            funct3_p0   <= i_req_funct3;
            lane_p0     <= i_req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
            wdata_p0    <= i_req_wdata;
            k_p0        <= '0;
            asm_p0      <= '0;
            split_p0    <= !req_illegal && req_misaligned;
            last_p0     <= last_idx(i_req_funct3[1:0]);
`endif
            if (req_illegal) begin
              state         <= S_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_illegal_q <= 1'b1;
            end else if (req_misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
              state       <= S_ACCESS;
              mem_addr_q  <= i_req_addr[ADDR_W-1:0];
              mem_bmask_q <= 4'b0001;
              mem_wdata_q <= {24'd0, i_req_wdata[7:0]};
              mem_wren_q  <= i_req_we;
`else
              state            <= S_RESP;
              rsp_valid_q      <= 1'b1;
              rsp_misaligned_q <= 1'b1;
`endif
            end else begin
              state       <= S_ACCESS;
              mem_addr_q  <= i_req_addr[ADDR_W-1:0];
              mem_bmask_q <= size_mask(i_req_funct3[1:0]);
              mem_wdata_q <= st_format(i_req_wdata, i_req_funct3[1:0]);
              mem_wren_q  <= i_req_we;
            end
          end
        end
        // Memory access
        S_ACCESS: begin
          if (split_more) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            k_p0        <= k_nxt;
            asm_p0      <= asm_next;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= {24'd0, wd_byte};
`endif
          end else begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_p0 ? '0 : ld_result;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            mem_wren_q  <= 1'b0;
          end
        end
        // Response hold
        S_RESP: begin
          if (i_rsp_ready) begin
            state            <= S_IDLE;
            req_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_misaligned_q <= 1'b0;
            rsp_illegal_q    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready      = req_ready_q;
  assign o_rsp_valid      = rsp_valid_q;
  assign o_rsp_rdata      = rsp_rdata_q;
  assign o_rsp_misaligned = rsp_misaligned_q;
  assign o_rsp_illegal    = rsp_illegal_q;
  assign o_mem_addr       = mem_addr_q;
  assign o_mem_wdata      = mem_wdata_q;
  assign o_mem_bmask      = mem_bmask_q;
  assign o_mem_wren       = mem_wren_q && !i_reset;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: byte-level reference memory plus request-level model of responses and bus writes.
module tb_lsu_mem_master;
  localparam int ADDR_W = 11;
  localparam int MSZ = 1 << ADDR_W;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [3:0]        m;
    logic [31:0]       d;
  } wr_t;

  logic              i_clk, i_reset;
  logic              i_req_valid, o_req_ready, i_req_we;
  logic [2:0]        i_req_funct3;
  logic [31:0]       i_req_addr, i_req_wdata;
  logic              o_rsp_valid, i_rsp_ready;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_misaligned, o_rsp_illegal;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  logic [7:0] env_mem [MSZ];
  logic [7:0] ref_mem [MSZ];
  logic       mem_init;
  wr_t        obs_q[$];
  wr_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_misaligned(o_rsp_misaligned),
    .o_rsp_illegal(o_rsp_illegal),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Memory environment: combinational word read, byte-masked write relative to the bus address.
  assign i_mem_rdata = {env_mem[{o_mem_addr[ADDR_W-1:2], 2'b11}], env_mem[{o_mem_addr[ADDR_W-1:2], 2'b10}],
                        env_mem[{o_mem_addr[ADDR_W-1:2], 2'b01}], env_mem[{o_mem_addr[ADDR_W-1:2], 2'b00}]};

  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < MSZ; i++) env_mem[i] <= ref_mem[i];
    end else if (o_mem_wren) begin
      for (int j = 0; j < 4; j++)
        if (o_mem_bmask[j]) env_mem[(int'(o_mem_addr) + j) % MSZ] <= o_mem_wdata[8*j +: 8];
    end
  end

  always @(negedge i_clk) begin
    if (o_mem_wren) obs_q.push_back(wr_t'({o_mem_addr, o_mem_bmask, o_mem_wdata}));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    int n;
    case (f3[1:0])
      2'b00:   n = 1;
      2'b01:   n = 2;
      default: n = 4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    logic [31:0] v;
    int n;
    v = '0;
    n = nbytes(f3);
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + k) % MSZ];
    if (n == 1 && !f3[2] && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !f3[2] && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One request end to end: model prediction, handshake, latency, response, bus writes, backpressure.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall,
                     output logic [31:0] rd, output logic ill_o, output logic mis_o);
    int a, n, cnt, exp_lat;
    logic ill, mis, rej_mis;
    logic [31:0] exp_rd;
    logic [3:0] m;
    a = int'(addr[ADDR_W-1:0]);
    n = nbytes(f3);
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    mis = !ill && n > 1 && (a % n != 0);
    rej_mis = mis && !SPLIT;
    exp_rd = '0;
    exp_q.delete();
    if (!ill && !rej_mis) begin
      if (we) begin
        if (mis) begin
          for (int k = 0; k < n; k++)
            exp_q.push_back(wr_t'({ADDR_W'((a + k) % MSZ), 4'b0001, 24'd0, wdata[8*k +: 8]}));
        end else begin
          m = (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
          exp_q.push_back(wr_t'({addr[ADDR_W-1:0], m,
                                 (n == 4) ? wdata : (wdata & ((32'd1 << (8*n)) - 32'd1))}));
        end
        for (int k = 0; k < n; k++) ref_mem[(a + k) % MSZ] = wdata[8*k +: 8];
      end else begin
        exp_rd = model_load(f3, a);
      end
    end
    exp_lat = (ill || rej_mis) ? 0 : (mis ? n : 1);

    cnt = 0;
    while (!o_req_ready && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
    end
    chk("req_ready_wait", o_req_ready, 1);
    obs_q.delete();
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3; i_req_addr = addr; i_req_wdata = wdata;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    cnt = 0;
    while (!o_rsp_valid && cnt < 10) begin
      @(negedge i_clk);
      cnt++;
    end
    chk("latency", cnt, exp_lat);
    chk("rsp_illegal", o_rsp_illegal, ill);
    chk("rsp_misaligned", o_rsp_misaligned, rej_mis);
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    chk("req_ready_busy", o_req_ready, 0);
    rd = o_rsp_rdata; ill_o = o_rsp_illegal; mis_o = o_rsp_misaligned;
    chk("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk("write_beat", obs_q[i], exp_q[i]);

    for (int s = 0; s < stall; s++) begin
      @(negedge i_clk);
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_rdata", o_rsp_rdata, exp_rd);
      chk("hold_ready", o_req_ready, 0);
      chk("idle_bus", {o_mem_wren, o_mem_bmask, o_mem_addr, o_mem_wdata}, 0);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk("rsp_dropped", o_rsp_valid, 0);
    chk("ready_after_accept", o_req_ready, 1);
  endtask

  logic [31:0] rd;
  logic        ill, mis;
  wr_t         w0;
  logic [ADDR_W-1:0] la [4];
  logic [7:0]        lb [4];

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = '0;
    i_req_addr = '0; i_req_wdata = '0; i_rsp_ready = 1'b0; mem_init = 1'b1;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'($urandom);
    repeat (2) @(negedge i_clk);
    mem_init = 1'b0;
    chk("rst_outputs", {o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_misaligned, o_rsp_illegal,
                        o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren}, 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("ready_after_reset", o_req_ready, 1);

    // Store accepted, then reset held two cycles while it is in flight.
    obs_q.delete();
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'd2;
    i_req_addr = 32'h0000_0040; i_req_wdata = 32'hCAFE_F00D;
    @(posedge i_clk);
    #1 i_reset = 1'b1; i_req_valid = 1'b0;
    #1 chk("rst_wren_gate", o_mem_wren, 0);
    @(negedge i_clk);
    chk("rst_wren_gate_neg", o_mem_wren, 0);
    @(negedge i_clk);
    chk("rst_mid_outputs", {o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_misaligned, o_rsp_illegal,
                            o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren}, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("ready_after_rst2", o_req_ready, 1);
    chk("rst_no_writes", obs_q.size(), 0);
    chk("rst_mem_intact", {env_mem[11'h043], env_mem[11'h042], env_mem[11'h041], env_mem[11'h040]},
                          {ref_mem[11'h043], ref_mem[11'h042], ref_mem[11'h041], ref_mem[11'h040]});

    txn(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd, ill, mis);
    w0 = '0;
    if (obs_q.size() > 0) w0 = obs_q[0];
    chk("sw10_bus", w0, wr_t'({11'h010, 4'hF, 32'hDEAD_BEEF}));
    txn(1'b0, 3'd2, 32'h0000_0010, 32'h0, 0, rd, ill, mis);
    chk("lw10_lit", rd, 32'hDEAD_BEEF);

    txn(1'b1, 3'd2, 32'h0000_0020, 32'h80FF_7F01, 1, rd, ill, mis);
    txn(1'b0, 3'd0, 32'h0000_0023, 32'h0, 0, rd, ill, mis);
    chk("lb23_lit", rd, 32'hFFFF_FF80);
    txn(1'b0, 3'd4, 32'h0000_0023, 32'h0, 0, rd, ill, mis);
    chk("lbu23_lit", rd, 32'h0000_0080);
    txn(1'b0, 3'd1, 32'h0000_0022, 32'h0, 0, rd, ill, mis);
    chk("lh22_lit", rd, 32'hFFFF_80FF);
    txn(1'b0, 3'd5, 32'h0000_0020, 32'h0, 0, rd, ill, mis);
    chk("lhu20_lit", rd, 32'h0000_7F01);
    txn(1'b0, 3'd2, 32'h0000_0020, 32'h0, 3, rd, ill, mis);
    chk("lw20_backpressure_lit", rd, 32'h80FF_7F01);

    txn(1'b1, 3'd3, 32'h0000_0030, 32'h1234_5678, 0, rd, ill, mis);
    chk("illegal_flag_lit", ill, 1);
    chk("illegal_rdata_lit", rd, 0);
    chk("illegal_no_write", obs_q.size(), 0);

    txn(1'b1, 3'd2, 32'h0000_07FF, 32'h1122_3344, 1, rd, ill, mis);
`ifdef LSU_MISALIGN_SPLIT_EN
    la = '{11'h7FF, 11'h000, 11'h001, 11'h002};
    lb = '{8'h44, 8'h33, 8'h22, 8'h11};
    chk("split_write_count_lit", obs_q.size(), 4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++)
      chk("split_write_lit", obs_q[k], wr_t'({la[k], 4'b0001, 24'd0, lb[k]}));
    txn(1'b0, 3'd2, 32'h0000_07FF, 32'h0, 0, rd, ill, mis);
    chk("split_readback_lit", rd, 32'h1122_3344);
`else
    chk("misaligned_flag_lit", mis, 1);
    chk("misaligned_no_write", obs_q.size(), 0);
`endif

    for (int t = 0; t < 300; t++) begin
      logic [10:0] sel;
      sel = ($urandom % 2 == 0) ? (11'h7F0 + 11'($urandom % 16)) : 11'($urandom % 64);
      txn(1'($urandom % 2), 3'($urandom % 8), ($urandom & 32'hFFFF_F800) | 32'(sel),
          $urandom, int'($urandom % 4), rd, ill, mis);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
